oam_dma: RTL

//  OAM DMA sequencer for the NES core. On a CPU write to $4014 it halts the
//  6502 through its CE input and copies the 256-byte page $XX00-$XXFF from the
//  CPU address space into PPU sprite memory (OAM), one byte per two CPU cycles.
//  It sits between the CPU memory router (read path) and the PPU OAM write port,
//  and it runs in the system clk domain, gated by a one-clk CPU-cycle strobe.

---
 rtl/oam_dma.sv | 120 ++++++++++++
 1 files changed

// File: rtl/oam_dma.sv
// OAM DMA sequencer: on a CPU write to REG_ADDR, halts the CPU and copies one
// 256-byte page from CPU space into PPU OAM, one byte every two CPU cycles.
module oam_dma #(
  parameter logic [15:0] REG_ADDR  = 16'h4014,
  parameter bit          ODD_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_tick,
  input  logic        wreq,
  input  logic [15:0] eawr,
  input  logic [7:0]  dout,
  input  logic [7:0]  oam_base,
  input  logic [7:0]  dma_din,
  output logic        cpu_halt,
  output logic        busy,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e      state_q;
  logic        parity_q;
  logic        odd_q;
  logic [7:0]  page_q;
  logic [7:0]  base_q;
  logic [7:0]  idx_q;
  logic        cpu_halt_q;
  logic        busy_q;
  logic        dma_rd_q;
  logic        oam_we_q;
  logic [7:0]  oam_addr_q;
  logic [7:0]  oam_data_q;

  logic trigger;
  assign trigger = wreq && (eawr == REG_ADDR);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      parity_q   <= 1'b0;
      odd_q      <= 1'b0;
      page_q     <= 8'h00;
      base_q     <= 8'h00;
      idx_q      <= 8'h00;
      cpu_halt_q <= 1'b0;
      busy_q     <= 1'b0;
      dma_rd_q   <= 1'b0;
      oam_we_q   <= 1'b0;
      oam_addr_q <= 8'h00;
      oam_data_q <= 8'h00;
    end else begin
      // The write strobe lasts one clk, not one CPU cycle, so it clears every clk.
      oam_we_q <= 1'b0;
      if (cpu_tick) begin
        parity_q <= ~parity_q;
        case (state_q)
          IDLE: begin
            if (trigger) begin
              page_q     <= dout;
              base_q     <= oam_base;
              odd_q      <= parity_q & ODD_ALIGN;
              idx_q      <= 8'h00;
              cpu_halt_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= ALIGN;
            end
          end
          ALIGN: begin
            // odd_q doubles as the extra-tick counter for odd-cycle triggers.
            if (odd_q) begin
              odd_q <= 1'b0;
            end else begin
              dma_rd_q <= 1'b1;
              state_q  <= READ;
            end
          end
          READ: begin
            state_q <= WRITE;
          end
          WRITE: begin
            oam_data_q <= dma_din;
            oam_addr_q <= base_q + idx_q;
            oam_we_q   <= 1'b1;
            if (idx_q == 8'hFF) begin
              cpu_halt_q <= 1'b0;
              busy_q     <= 1'b0;
              dma_rd_q   <= 1'b0;
              state_q    <= IDLE;
            end else begin
              idx_q   <= idx_q + 8'd1;
              state_q <= READ;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cpu_halt = cpu_halt_q;
  assign busy     = busy_q;
  assign dma_rd   = dma_rd_q;
  assign dma_addr = {page_q, idx_q};
  assign oam_we   = oam_we_q;
  assign oam_addr = oam_addr_q;
  assign oam_data = oam_data_q;

endmodule
